// File: rtl/raw_pkg.sv
// Shared constants, state encoding and word helpers for the raw-hit readout path.
package raw_pkg;

    localparam int DIN_W  = 576;
    localparam int OUT_W  = 16;
    localparam int MAX_FR = 32;
    localparam int WPF    = DIN_W / OUT_W;
    localparam int AW     = 5;

    localparam logic [3:0] HDR_TAG   = 4'hA;
    localparam logic [5:0] LAST_WORD = 6'(WPF - 1);
    localparam logic [5:0] MAX_N     = 6'(MAX_FR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } state_e;

    function automatic logic [OUT_W-1:0] make_header(input logic [5:0] n);
        return {HDR_TAG, 6'd0, n};
    endfunction

    // Word j of a frame, LSB-first ordering.
    function automatic logic [OUT_W-1:0] word_sel(input logic [DIN_W-1:0] frame,
                                                  input logic [5:0]       j);
        return frame[int'(j)*OUT_W +: OUT_W];
    endfunction

endpackage

// File: rtl/raw_frame_ram.sv
// Simple dual-port frame store with a registered read port (1-cycle latency).
module raw_frame_ram
    import raw_pkg::*;
#(
    parameter int DEPTH  = MAX_FR,
    parameter int WIDTH  = DIN_W,
    parameter int ADDR_W = AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port; a same-address write forwards the new data so a one-frame
    // capture can be read on the very edge it is written.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/raw_readout.sv
// Captures a trigger window of delayed raw frames, freezes the delay line and
// streams the window as a header plus 16-bit words over valid/ready.
module raw_readout
    import raw_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIN_W-1:0] din,
    input  logic             trig,
    input  logic [5:0]       nframes,
    output logic             trig_stop,
    output logic             busy,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic [7:0]       lost_trig
);

    state_e           state_q, state_d;
    logic [5:0]       n_q, n_d;
    logic [5:0]       frm_q, frm_d;
    logic [5:0]       wrd_q, wrd_d;
    logic             hdr_q, hdr_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             stop_q, stop_d;
    logic             busy_q, busy_d;
    logic [7:0]       lost_q, lost_d;

    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic             re_s;
    logic [AW-1:0]    raddr_s;
    logic [DIN_W-1:0] rdata_s;

    logic             xfer_s;
    logic             done_s;
    logic [5:0]       nxt_frm_s;
    logic [5:0]       nxt_wrd_s;

    raw_frame_ram u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (din),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Position of the word that follows the one currently presented on dout.
    always_comb begin
        xfer_s    = valid_q & dout_ready;
        done_s    = 1'b0;
        nxt_frm_s = frm_q;
        nxt_wrd_s = wrd_q;
        if (hdr_q) begin
            nxt_frm_s = 6'd0;
            nxt_wrd_s = 6'd0;
        end else if (wrd_q == LAST_WORD) begin
            nxt_frm_s = frm_q + 6'd1;
            nxt_wrd_s = 6'd0;
            done_s    = (frm_q == (n_q - 6'd1));
        end else begin
            nxt_wrd_s = wrd_q + 6'd1;
        end
    end

    // Next-state, counters, RAM control and registered output values.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        frm_d   = frm_q;
        wrd_d   = wrd_q;
        hdr_d   = hdr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        stop_d  = stop_q;
        busy_d  = busy_q;
        lost_d  = lost_q;
        we_s    = 1'b0;
        waddr_s = frm_q[AW-1:0];
        re_s    = 1'b0;
        raddr_s = {AW{1'b0}};

        if (trig && (state_q != IDLE) && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end else begin
            lost_d = lost_q;
        end

        case (state_q)
            IDLE: begin
                if (trig && (nframes != 6'd0)) begin
                    n_d     = (nframes > MAX_N) ? MAX_N : nframes;
                    frm_d   = 6'd0;
                    state_d = CAPTURE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                we_s = 1'b1;
                if (frm_q == (n_q - 6'd1)) begin
                    // Fetch frame 0 now so it sits on the RAM output while the header is shown.
                    re_s    = 1'b1;
                    raddr_s = {AW{1'b0}};
                    state_d = READOUT;
                    frm_d   = 6'd0;
                    wrd_d   = 6'd0;
                    hdr_d   = 1'b1;
                    dout_d  = make_header(n_q);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    stop_d  = 1'b1;
                end else begin
                    frm_d = frm_q + 6'd1;
                end
            end
            READOUT: begin
                if (xfer_s && done_s) begin
                    state_d = IDLE;
                    hdr_d   = 1'b0;
                    frm_d   = 6'd0;
                    wrd_d   = 6'd0;
                    dout_d  = {OUT_W{1'b0}};
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    stop_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer_s) begin
                    hdr_d   = 1'b0;
                    frm_d   = nxt_frm_s;
                    wrd_d   = nxt_wrd_s;
                    dout_d  = word_sel(rdata_s, nxt_wrd_s);
                    last_d  = (nxt_frm_s == (n_q - 6'd1)) && (nxt_wrd_s == LAST_WORD);
                    // Prefetch the next frame once its predecessor's last word is loaded.
                    if ((nxt_wrd_s == LAST_WORD) && (nxt_frm_s != (n_q - 6'd1))) begin
                        re_s    = 1'b1;
                        raddr_s = 5'(nxt_frm_s + 6'd1);
                    end else begin
                        re_s = 1'b0;
                    end
                end else begin
                    state_d = READOUT;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                stop_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 6'd0;
            frm_q   <= 6'd0;
            wrd_q   <= 6'd0;
            hdr_q   <= 1'b0;
            dout_q  <= {OUT_W{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            lost_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            frm_q   <= frm_d;
            wrd_q   <= wrd_d;
            hdr_q   <= hdr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            lost_q  <= lost_d;
        end
    end

    assign trig_stop  = stop_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign lost_trig  = lost_q;

endmodule

// File: tb/tb_raw_readout.sv
// Bench for raw_readout: packet-level reference model checked every cycle plus pinned literals.
module tb_raw_readout;
    import raw_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIN_W-1:0] din = '0;
    logic             trig = 1'b0;
    logic [5:0]       nframes = 6'd0;
    logic             trig_stop;
    logic             busy;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             dout_last;
    logic [7:0]       lost_trig;

    raw_readout dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .trig       (trig),
        .nframes    (nframes),
        .trig_stop  (trig_stop),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .lost_trig  (lost_trig)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input drivers: din pattern and dout_ready, updated 1 time unit after each rising edge.
    int         din_mode = 0;
    int         rdy_rand = 0;
    logic       rdy_fix = 1'b1;
    logic [15:0] din_cnt = 16'd0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            din_cnt++;
            for (int j = 0; j < WPF; j++) begin
                case (din_mode)
                    0:       din[j*16 +: 16] = 16'h0100 + 16'(j);
                    1:       din[j*16 +: 16] = din_cnt;
                    default: din[j*16 +: 16] = {din_cnt[9:0], 6'(j)};
                endcase
            end
            dout_ready = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Reference model: mode 0 idle, 1 capturing, 2 streaming.
    int               m_mode = 0;
    int               m_left = 0;
    int               m_n = 0;
    int               m_lost = 0;
    logic [15:0]      exp_q[$];
    logic [DIN_W-1:0] frames[$];
    logic [15:0]      obs[$];
    int               last_cnt = 0;
    int               stop_cnt = 0;
    int               valid_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_stop", trig_stop, 0);
                chk("rst_valid", dout_valid, 0);
                chk("rst_last", dout_last, 0);
                chk("rst_dout", dout, 0);
                chk("rst_lost", lost_trig, 0);
                m_mode = 0;
                m_lost = 0;
                exp_q.delete();
                frames.delete();
            end else begin
                chk("busy", busy, (m_mode != 0));
                chk("trig_stop", trig_stop, (m_mode == 2));
                chk("dout_valid", dout_valid, (m_mode == 2));
                chk("lost_trig", lost_trig, 64'(m_lost));
                if (m_mode == 2) begin
                    chk("dout", dout, exp_q[0]);
                    chk("dout_last", dout_last, (exp_q.size() == 1));
                end
                if (dout_valid && dout_ready) begin
                    obs.push_back(dout);
                    if (dout_last) last_cnt++;
                end
                if (trig_stop) stop_cnt++;
                if (dout_valid) valid_cnt++;

                if (trig && (m_mode != 0) && (m_lost < 255)) m_lost++;
                case (m_mode)
                    0: begin
                        if (trig && (nframes != 6'd0)) begin
                            m_n    = (int'(nframes) > MAX_FR) ? MAX_FR : int'(nframes);
                            m_left = m_n;
                            frames.delete();
                            m_mode = 1;
                        end
                    end
                    1: begin
                        frames.push_back(din);
                        m_left--;
                        if (m_left == 0) begin
                            exp_q.delete();
                            exp_q.push_back({4'hA, 6'd0, 6'(m_n)});
                            foreach (frames[k])
                                for (int j = 0; j < WPF; j++)
                                    exp_q.push_back(frames[k][j*16 +: 16]);
                            m_mode = 2;
                        end
                    end
                    default: begin
                        if (dout_ready) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) m_mode = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig(input logic [5:0] nf);
        step(1);
        trig    = 1'b1;
        nframes = nf;
        step(1);
        trig    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while ((busy || dout_valid) && (c < budget)) begin
            step(1);
            c++;
        end
        if (c >= budget) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, c);
        end
        step(2);
    endtask

    task automatic clear_logs();
        obs.delete();
        last_cnt  = 0;
        stop_cnt  = 0;
        valid_cnt = 0;
    endtask

    initial begin
        int c;
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("pin_reset_lost", lost_trig, 0);

        // nframes = 0 is ignored entirely
        pulse_trig(6'd0);
        step(3);
        chk("pin_n0_busy", busy, 0);
        chk("pin_n0_lost", lost_trig, 0);

        // single frame, ready held high
        din_mode = 0; rdy_rand = 0; rdy_fix = 1'b1;
        clear_logs();
        pulse_trig(6'd1);
        wait_idle(200, "n1");
        chk("pin_n1_size", obs.size(), 37);
        chk("pin_n1_hdr", obs[0], 16'hA001);
        chk("pin_n1_w0", obs[1], 16'h0100);
        chk("pin_n1_w35", obs[36], 16'h0123);
        chk("pin_n1_stop", stop_cnt, 37);
        chk("pin_n1_last", last_cnt, 1);

        // three frames, no bubbles across frame boundaries
        din_mode = 2;
        clear_logs();
        pulse_trig(6'd3);
        wait_idle(400, "n3");
        chk("pin_n3_size", obs.size(), 109);
        chk("pin_n3_valid_cycles", valid_cnt, 109);

        // full depth with random back-pressure
        din_mode = 1; rdy_rand = 1;
        clear_logs();
        pulse_trig(6'd32);
        wait_idle(20000, "n32");
        chk("pin_n32_size", obs.size(), 1153);
        chk("pin_n32_hdr", obs[0], 16'hA020);
        chk("pin_n32_order", 16'(obs[1152] - obs[1]), 16'd31);
        chk("pin_n32_last", last_cnt, 1);

        // ignored triggers during capture and a long stall
        rdy_rand = 0; rdy_fix = 1'b0; din_mode = 2;
        clear_logs();
        pulse_trig(6'd2);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        step(4);
        trig = 1'b1;
        step(300);
        trig = 1'b0;
        rdy_fix = 1'b1;
        wait_idle(400, "lost");
        chk("pin_lost_sat", lost_trig, 8'd255);
        chk("pin_lost_size", obs.size(), 73);
        chk("pin_lost_hdr", obs[0], 16'hA002);

        // nframes above depth clamps to 32
        clear_logs();
        pulse_trig(6'd40);
        wait_idle(3000, "n40");
        chk("pin_n40_hdr", obs[0], 16'hA020);
        chk("pin_n40_size", obs.size(), 1153);
        chk("pin_n40_lost", lost_trig, 8'd255);

        // reset at word 10 of frame 2, then a clean packet
        clear_logs();
        pulse_trig(6'd4);
        c = 0;
        while ((obs.size() < 83) && (c < 1000)) begin
            step(1);
            c++;
        end
        chk("pin_mid_reached", (obs.size() >= 83), 1);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("pin_mid_busy", busy, 0);
        chk("pin_mid_lost", lost_trig, 0);
        clear_logs();
        pulse_trig(6'd2);
        wait_idle(400, "n2");
        chk("pin_n2_size", obs.size(), 73);
        chk("pin_n2_hdr", obs[0], 16'hA002);
        chk("pin_n2_last", last_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/raw_readout.md
Name: raw_readout

Overview:
- Reader side of the raw-hit delay line.
- On an L1-style trigger it captures a window of consecutive delayed 576-bit raw frames into a local block RAM.
- It then freezes the delay line by asserting `trig_stop` and serialises the window as 16-bit words over a valid/ready stream to the DAQ FIFO.
- It sits between the delay line output and the readout multiplexer.

Parameters:
- DIN_W, 576, raw frame width; must be a multiple of OUT_W.
- OUT_W, 16, output word width.
- MAX_FR, 32, maximum captured frames (local RAM depth).
- WPF, DIN_W/OUT_W = 36, output words per frame (derived, not overridable).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DIN_W  delayed raw frame, one per clk.
- trig  in  1  single-cycle capture request.
- nframes  in  6  frames to capture; sampled only on an accepted trig.
- trig_stop  out  1  freezes the delay line during readout.
- busy  out  1  high in CAPTURE or READOUT.
- dout  out  OUT_W  output word.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts dout.
- dout_last  out  1  final word of the packet; qualified by dout_valid.
- lost_trig  out  8  saturating count of ignored triggers.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. trig_stop, busy, dout, dout_valid, dout_last and lost_trig all 0. Internal counters 0. RAM contents are don't-care.
- States: IDLE, CAPTURE, READOUT.
- IDLE:
  - trig=1 with nframes=0: ignored, lost_trig unchanged.
  - trig=1 with nframes>0: latch n = min(nframes, MAX_FR), go to CAPTURE.
- CAPTURE:
  - Writes din to ram[k] for k=0..n-1 on consecutive cycles, starting the cycle after trig.
  - With trig sampled at cycle T, frames are written at T+1..T+n, and READOUT is entered at T+n+1.
  - trig_stop=0 throughout, so the delay line keeps running.
- READOUT:
  - trig_stop=1 from the first READOUT cycle until the cycle after the last word is accepted.
  - dout_valid rises at T+n+1. First word is the header {4'hA, 6'b0, n[5:0]}.
  - Then n frames follow, each as WPF words. Word j of frame k = ram[k][16j+15:16j], j ascending, LSB first.
  - Total packet = 1 + 36n words. dout_last=1 only on the final word.
- Handshake:
  - A word transfers when dout_valid & dout_ready.
  - While dout_valid=1 and dout_ready=0, dout and dout_last hold stable.
  - dout_valid never drops before its word transfers.
  - With dout_ready held high, words transfer on consecutive cycles with no bubbles, including across frame boundaries. The RAM read latency (1 cycle) must be hidden by prefetching frame k+1 before word 35 of frame k transfers.
- Completion: on transfer of the last word, go to IDLE. dout_valid=0, trig_stop=0 and busy=0 from the next cycle. A trig in that same cycle counts as lost.
- Ignored triggers: trig in CAPTURE or READOUT does not restart capture. It increments lost_trig, which saturates at 255 and is cleared only by rst_n.
- Mid-operation reset: rst_n low mid-CAPTURE or mid-READOUT aborts immediately; all outputs take their reset values and no partial packet is resumed.
- Width rules: frame counter 6 bits, word counter 6 bits (0..35, wraps to 0 with frame increment), header n field 6 bits.

Decomposition:
- Shared package raw_pkg:
  - DIN_W, OUT_W, WPF.
  - HDR_TAG = 4'hA.
  - State enum {IDLE, CAPTURE, READOUT}.
- One sub-module: raw_frame_ram, a simple dual-port MAX_FR x DIN_W block RAM with a registered read port and 1-cycle latency. The FSM, counters and slice mux stay in raw_readout.

Test Plan:
- nframes=1, din=frame with word j = 16'h0100+j, dout_ready=1 -> header 16'hA001 at T+2, then 16'h0100..16'h0123 on consecutive cycles; dout_last on 37th word; trig_stop high exactly 37 cycles.
- nframes=32, din = incrementing frame index in every word, random dout_ready (50%) -> 1153 words, data order frame 0..31 and word 0..35, dout stable whenever ready=0, exactly one dout_last.
- nframes=0 -> no state change, lost_trig=0. nframes=40 -> header 16'hA020, 1153 words.
- Second trig during CAPTURE and 300 trigs during a long stalled READOUT -> packet unaffected, lost_trig saturates at 255.
- rst_n asserted at word 10 of frame 2, then released; new trig with nframes=2 -> clean packet, header 16'hA002, 73 words, no stale data.
- dout_ready=1 throughout, n=3 -> no dout_valid gap at frame boundaries (words 36/37 and 72/73 on adjacent cycles).
